// File: rtl/pipe_pkg.sv
// Shared pipeline types: register index width, ALU op encoding and the
// per-instruction control bundle carried from ID through EX.
package pipe_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11,
        ALU_R12  = 4'd12,
        ALU_R13  = 4'd13,
        ALU_R14  = 4'd14,
        ALU_R15  = 4'd15
    } aluop_t;

    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   memtoreg;
        logic   alusrc;
        aluop_t aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        regwrite: 1'b0,
        memread:  1'b0,
        memwrite: 1'b0,
        memtoreg: 1'b0,
        alusrc:   1'b0,
        aluop:    ALU_ADD
    };

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load sitting in EX and
// the instruction currently being decoded.
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    output logic              lu
);

    logic rs_hit;
    logic rt_hit;

    // r0 is hardwired, so a load targeting it can never feed a consumer
    assign rs_hit = (ex_rd == id_rs);
    assign rt_hit = id_uses_rt & (ex_rd == id_rt);
    assign lu     = ex_valid & ex_memread & (ex_rd != '0) & id_valid & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional ID_EX_STALL_CNT_EN adds a free-running 32-bit stall counter port.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rt,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_memtoreg,
    input  logic              id_alusrc,
    input  logic [3:0]        id_aluop,
    input  logic              flush,
    input  logic              hold,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic              ex_alusrc,
    output logic [3:0]        ex_aluop,
`ifdef ID_EX_STALL_CNT_EN
    output logic [31:0]       stall_count,
`endif
    output logic              stall
);

    logic              valid_q,   valid_d;
    logic [DATA_W-1:0] pc_q,      pc_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    logic [REG_AW-1:0] rs_q,      rs_d;
    logic [REG_AW-1:0] rt_q,      rt_d;
    logic [REG_AW-1:0] rd_q,      rd_d;
    ctrl_t             ctrl_q,    ctrl_d;
    ctrl_t             id_ctrl;
    logic              lu;

    assign id_ctrl = '{
        regwrite: id_regwrite,
        memread:  id_memread,
        memwrite: id_memwrite,
        memtoreg: id_memtoreg,
        alusrc:   id_alusrc,
        aluop:    aluop_t'(id_aluop)
    };

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_lu (
        .ex_valid   (valid_q),
        .ex_memread (ctrl_q.memread),
        .ex_rd      (rd_q),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .lu         (lu)
    );

    // A hold freezes upstream globally; a flush kills the ID instruction anyway
    assign stall = lu & ~flush & ~hold;

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        ctrl_d    = ctrl_q;
        // Bubbles zero the indices too so forwarding never matches them
        if (flush || (!hold && lu)) begin
            valid_d   = 1'b0;
            pc_d      = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            rs_d      = '0;
            rt_d      = '0;
            rd_d      = '0;
            ctrl_d    = CTRL_NOP;
        end else if (!hold) begin
            valid_d   = id_valid;
            pc_d      = id_pc;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = id_imm;
            rs_d      = id_rs;
            rt_d      = id_rt;
            rd_d      = id_rd;
            ctrl_d    = id_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            ctrl_q    <= CTRL_NOP;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rs_data  = rs_data_q;
    assign ex_rt_data  = rt_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_rd       = rd_q;
    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_memread  = ctrl_q.memread;
    assign ex_memwrite = ctrl_q.memwrite;
    assign ex_memtoreg = ctrl_q.memtoreg;
    assign ex_alusrc   = ctrl_q.alusrc;
    assign ex_aluop    = ctrl_q.aluop;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // stall already excludes hold and flush cycles; wraps naturally at 2^32
    assign stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule
